// File: rtl/ov7670_pkg.sv
// Shared types, table markers and helpers for the OV7670 configuration path.
// OV_CFG_TIMEOUT_EN adds the ERROR state used by the SCCB ready watchdog.
package ov7670_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_SEND      = 4'd3,
    ST_WAIT_ACK  = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_DELAY     = 4'd6,
    ST_NEXT      = 4'd7,
    ST_DONE      = 4'd8
`ifdef OV_CFG_TIMEOUT_EN
    , ST_ERROR   = 4'd9
`endif
  } cfg_state_t;

  localparam logic [15:0] CFG_END_MARKER   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY_MARKER = 16'hFFF0;
  localparam logic [7:0]  OV7670_SCCB_ID   = 8'h42;

  function automatic logic [31:0] ms_to_cycles(input int clk_freq, input int ms);
    return 32'(clk_freq / 1000 * ms);
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Synchronous ROM holding the OV7670 boot register table ({reg_addr, reg_data} per entry).
// Data appears one clk_en cycle after addr changes; unused slots read as the end marker.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int  ROM_DEPTH = 128,
  localparam int AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          clk_en,
  input  logic [AW-1:0] addr,
  output logic [15:0]   data
);

  function automatic logic [15:0] entry(input logic [AW-1:0] a);
    case (int'(a))
      0:       entry = {8'h12, 8'h80};   // COM7 soft reset, needs the settle delay below
      1:       entry = CFG_DELAY_MARKER;
      2:       entry = {8'h12, 8'h04};   // COM7: RGB output
      3:       entry = {8'h11, 8'h01};   // CLKRC prescaler
      4:       entry = {8'h0C, 8'h00};
      5:       entry = {8'h3E, 8'h00};
      6:       entry = {8'h40, 8'hD0};   // COM15: RGB565, full range
      7:       entry = {8'h8C, 8'h00};
      8:       entry = {8'h3A, 8'h04};
      9:       entry = {8'h3D, 8'hC8};
      default: entry = CFG_END_MARKER;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (clk_en) data <= entry(addr);
  end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Boot-time OV7670 sequencer: walks the register table and issues one SCCB write per entry.
// Define OV_CFG_TIMEOUT_EN to add the ready watchdog, the ERROR state and the cfg_error port.
module ov7670_cfg_sequencer
  import ov7670_pkg::*;
#(
  parameter int  CLK_FREQ       = 25000000,
  parameter int  ROM_DEPTH      = 128,
  parameter int  DELAY_MS       = 10,
  parameter bit  AUTO_START     = 1'b1,
  parameter int  TIMEOUT_CYCLES = 100000,
  localparam int AW             = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          sccb_ready,
  output logic          sccb_start,
  output logic [7:0]    sccb_address,
  output logic [7:0]    sccb_data,
  output logic          busy,
  output logic          done,
  output logic [7:0]    write_count,
`ifdef OV_CFG_TIMEOUT_EN
  output logic          cfg_error,
`endif
  output logic [3:0]    dbg_state
);

  localparam logic [31:0]   DELAY_CYCLES = ms_to_cycles(CLK_FREQ, DELAY_MS);
  localparam logic [31:0]   DELAY_LOAD   = (DELAY_CYCLES == 32'd0) ? 32'd0 : DELAY_CYCLES - 32'd1;
  localparam logic [AW-1:0] LAST_ADDR    = AW'(ROM_DEPTH - 1);

  // SCCB handshake: sccb_start is a one-clk_en-cycle request, only raised while sccb_ready = 1;
  // the master acknowledges by dropping sccb_ready and signals completion by raising it again.
  cfg_state_t    state, state_d;
  logic [AW-1:0] addr_d;
  logic          start_d, busy_d, done_d, first_pass, first_d;
  logic [7:0]    reg_addr_d, reg_data_d, wcount_d;
  logic [31:0]   dly_cnt, dly_d;
  logic          launch, finish;
`ifdef OV_CFG_TIMEOUT_EN
  logic [31:0]   wd_cnt, wd_d;
  logic          err_d;
`endif

  assign dbg_state = state;

  always_comb begin
    state_d    = state;
    addr_d     = rom_addr;
    start_d    = 1'b0;
    reg_addr_d = sccb_address;
    reg_data_d = sccb_data;
    busy_d     = busy;
    done_d     = done;
    wcount_d   = write_count;
    dly_d      = dly_cnt;
    first_d    = first_pass;
    launch     = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:   launch = start || (AUTO_START && first_pass);
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (rom_data == CFG_END_MARKER) begin
          finish = 1'b1;
        end else if (rom_data == CFG_DELAY_MARKER) begin
          dly_d   = DELAY_LOAD;
          state_d = ST_DELAY;
        end else begin
          reg_addr_d = rom_data[15:8];
          reg_data_d = rom_data[7:0];
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sccb_ready) begin
          start_d = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: if (!sccb_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sccb_ready) begin
          if (write_count != 8'hFF) wcount_d = write_count + 8'd1;
          state_d = ST_NEXT;
        end
      end
      ST_DELAY: begin
        if (dly_cnt == 32'd0) state_d = ST_NEXT;
        else                  dly_d   = dly_cnt - 32'd1;
      end
      ST_NEXT: begin
        // Running off the last slot acts as an end marker; the address never wraps.
        if (rom_addr == LAST_ADDR) begin
          finish = 1'b1;
        end else begin
          addr_d  = rom_addr + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: launch = start;
`ifdef OV_CFG_TIMEOUT_EN
      ST_ERROR: launch = start;
`endif
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

`ifdef OV_CFG_TIMEOUT_EN
    // Counts every clk_en cycle the master keeps us waiting across WAIT_ACK and WAIT_DONE.
    wd_d  = '0;
    err_d = cfg_error;
    if ((state == ST_WAIT_ACK || state == ST_WAIT_DONE) &&
        (state_d == ST_WAIT_ACK || state_d == ST_WAIT_DONE)) begin
      wd_d = wd_cnt + 32'd1;
      if (wd_d >= 32'(TIMEOUT_CYCLES)) begin
        state_d = ST_ERROR;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b1;
        wd_d    = '0;
      end
    end
`endif

    if (launch) begin
      state_d  = ST_FETCH;
      addr_d   = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      wcount_d = '0;
      first_d  = 1'b0;
`ifdef OV_CFG_TIMEOUT_EN
      err_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rom_addr     <= '0;
      sccb_start   <= 1'b0;
      sccb_address <= '0;
      sccb_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      write_count  <= '0;
      dly_cnt      <= '0;
      first_pass   <= 1'b1;
`ifdef OV_CFG_TIMEOUT_EN
      wd_cnt       <= '0;
      cfg_error    <= 1'b0;
`endif
    end else if (clk_en) begin
      state        <= state_d;
      rom_addr     <= addr_d;
      sccb_start   <= start_d;
      sccb_address <= reg_addr_d;
      sccb_data    <= reg_data_d;
      busy         <= busy_d;
      done         <= done_d;
      write_count  <= wcount_d;
      dly_cnt      <= dly_d;
      first_pass   <= first_d;
`ifdef OV_CFG_TIMEOUT_EN
      wd_cnt       <= wd_d;
      cfg_error    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Randomised scoreboard bench for ov7670_cfg_sequencer with a behavioural SCCB master and table ROM.
// Define OV_CFG_TIMEOUT_EN to also exercise the watchdog.
module tb_ov7670_cfg_sequencer;
  localparam int CLK_FREQ = 20000;
  localparam int DELAY_MS = 1;
  localparam int D        = CLK_FREQ / 1000 * DELAY_MS;
  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int TMO      = 50;

  logic          clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic          sccb_ready = 1'b1;
  logic          sccb_start, busy, done;
  logic [7:0]    sccb_address, sccb_data, write_count;
  logic [3:0]    dbg_state;
`ifdef OV_CFG_TIMEOUT_EN
  logic          cfg_error;
`endif

  logic [15:0] rom [DEPTH];
  logic [23:0] exp_q[$];            // {delay markers since previous write, reg_addr, reg_data}
  int checks = 0, errors = 0;
  int ce_cnt = 0, rise_ref = 0, launch_ref = 0;
  int m_phase = 0, m_cnt = 0;
  int exp_wc = 0, exp_last = 0;
  bit stuck = 1'b0;

  ov7670_cfg_sequencer #(
    .CLK_FREQ(CLK_FREQ), .ROM_DEPTH(DEPTH), .DELAY_MS(DELAY_MS),
    .AUTO_START(1'b1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data), .sccb_ready(sccb_ready),
    .sccb_start(sccb_start), .sccb_address(sccb_address), .sccb_data(sccb_data),
    .busy(busy), .done(done), .write_count(write_count),
`ifdef OV_CFG_TIMEOUT_EN
    .cfg_error(cfg_error),
`endif
    .dbg_state(dbg_state)
  );

  // clock / enable
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #2 clk_en = ($urandom_range(0, 3) != 0);
  end

  // synchronous table ROM and SCCB master model, both advancing on clk_en
  always @(posedge clk) if (clk_en) rom_data <= rom[rom_addr];
  always @(posedge clk) if (clk_en) ce_cnt <= ce_cnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sccb_ready <= 1'b1;
      m_phase    <= 0;
      m_cnt      <= 0;
    end else if (clk_en) begin
      case (m_phase)
        0: if (sccb_start) begin
          m_cnt   <= $urandom_range(0, 3);
          m_phase <= 1;
        end
        1: if (m_cnt == 0) begin
          sccb_ready <= 1'b0;
          m_cnt      <= $urandom_range(1, 5);
          m_phase    <= 2;
        end else m_cnt <= m_cnt - 1;
        default: if (!stuck) begin
          if (m_cnt <= 1) begin
            sccb_ready <= 1'b1;
            m_phase    <= 0;
            rise_ref   <= ce_cnt + 1;
          end else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // reference model: the writes a full pass over the table must produce
  task automatic build_expected();
    int k = 0;
    exp_wc   = 0;
    exp_last = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_last = i;
        break;
      end else if (rom[i] == 16'hFFF0) begin
        k++;
      end else begin
        exp_q.push_back({8'(k), rom[i]});
        k = 0;
        exp_wc++;
      end
    end
    if (exp_wc > 255) exp_wc = 255;
  endtask

  // scoreboard monitor: every accepted sccb_start must match the next expected write
  always @(negedge clk) begin
    logic [23:0] e;
    int gap, k, ref_t;
    bit ok;
    if (rst_n && clk_en && sccb_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %02h/%02h, expected no write", sccb_address, sccb_data);
      end else begin
        e = exp_q.pop_front();
        check("write", 64'({sccb_address, sccb_data}), 64'(e[15:0]));
        ref_t = (rise_ref > launch_ref) ? rise_ref : launch_ref;
        gap   = ce_cnt - ref_t;
        k     = int'(e[23:16]);
        ok    = (k == 0) ? (gap < D) : (gap >= k * D && gap <= k * (D + 8) + 8);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL write_gap: got %0d cycles, expected about %0d (delay markers %0d)", gap, k * D, k);
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input bit is_launch);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (clk_en) break;
    end
    #1;
    start = 1'b0;
    if (is_launch) launch_ref = ce_cnt;
  endtask

  task automatic launch_run(input string tag);
    build_expected();
    pulse_start(1'b1);
    check({tag, "_launch_busy"}, 64'(busy), 64'd1);
    check({tag, "_launch_done"}, 64'(done), 64'd0);
    check({tag, "_launch_count"}, 64'(write_count), 64'd0);
  endtask

  task automatic wait_finish(input string tag);
    bit poked = 1'b0, seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!poked && busy && !sccb_ready && $urandom_range(0, 3) == 0) begin
        poked = 1'b1;
        pulse_start(1'b0);
      end
    end
    check({tag, "_done_busy"}, 64'({seen, done, busy}), 64'b110);
    check({tag, "_count"}, 64'(write_count), 64'(exp_wc));
    check({tag, "_last_addr"}, 64'(rom_addr), 64'(exp_last));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic random_table();
    for (int i = 0; i < DEPTH; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 12)      rom[i] = 16'hFFF0;
      else if (r < 20) rom[i] = 16'hFFFF;
      else             rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
    end
  endtask

  initial begin
    bit found;
    rom = '{16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sccb_start", 64'(sccb_start), 64'd0);
    check("reset_count", 64'(write_count), 64'd0);
    check("reset_rom_addr", 64'(rom_addr), 64'd0);
    check("reset_sccb_bus", 64'({sccb_address, sccb_data}), 64'd0);

    build_expected();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    launch_ref = ce_cnt;
    wait_finish("auto");

    for (int i = 0; i < DEPTH; i++) rom[i] = {8'(i * 3 + 1), 8'($urandom_range(0, 255))};
    launch_run("noend");
    wait_finish("noend");

    for (int n = 0; n < 8; n++) begin
      random_table();
      launch_run("rand");
      wait_finish("rand");
    end

    rom = '{16'h1101, 16'h0C00, 16'hFFF0, 16'h3E00, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    launch_run("midreset");
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (busy && !sccb_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("midreset_reached_wait", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          64'({busy, done, sccb_start, write_count, rom_addr, sccb_address, sccb_data}), 64'd0);
    exp_q.delete();
    build_expected();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch_ref = ce_cnt;
    wait_finish("restart");

`ifdef OV_CFG_TIMEOUT_EN
    begin
      int t_fall = 0;
      bit fell = 1'b0, hit = 1'b0;
      rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      launch_run("timeout");
      stuck = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (!fell && !sccb_ready) begin
          fell   = 1'b1;
          t_fall = ce_cnt;
        end
        if (cfg_error) begin
          hit = 1'b1;
          break;
        end
      end
      check("timeout_flags", 64'({hit, cfg_error, busy, done}), 64'b1100);
      checks++;
      if (!(ce_cnt - t_fall >= TMO - 8 && ce_cnt - t_fall <= TMO)) begin
        errors++;
        $display("FAIL timeout_latency: got %0d cycles, expected about %0d", ce_cnt - t_fall, TMO);
      end
      exp_q.delete();
      stuck = 1'b0;
      repeat (20) @(negedge clk);
      check("timeout_error_held", 64'(cfg_error), 64'd1);
      launch_run("recover");
      check("recover_error_clear", 64'(cfg_error), 64'd0);
      wait_finish("recover");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
